// File: rtl/n101_uartrx.sv
// n101 UART receiver: 8N1/8N2, LSB first, oversampled by io_div.
// One-entry holding buffer, valid/ready drain, error pulses.
module n101_uartrx (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_en,
  input  logic        io_in,
  input  logic [15:0] io_div,
  input  logic        io_nstop,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [7:0]  io_out_bits,
  output logic        io_frame_err,
  output logic        io_overrun,
  output logic        io_busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e      state_q, state_d;
  logic        s1_q, rx_q, rxd_q;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic        scnt_q, scnt_d;
  logic        valid_q, valid_d;
  logic [7:0]  bits_q, bits_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;

  logic fall, sample, accept, active;

  assign fall   = rxd_q & ~rx_q;
  assign active = (state_q != IDLE);
  assign sample = active && (presc_q == 16'd0);
  assign accept = valid_q & io_out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q  <= 1'b1;
      rx_q  <= 1'b1;
      rxd_q <= 1'b1;
    end else begin
      s1_q  <= io_in;
      rx_q  <= s1_q;
      rxd_q <= rx_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      presc_q <= 16'd0;
      shift_q <= 8'd0;
      bcnt_q  <= 3'd0;
      scnt_q  <= 1'b0;
      valid_q <= 1'b0;
      bits_q  <= 8'd0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
      valid_q <= valid_d;
      bits_q  <= bits_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    scnt_d  = scnt_q;
    valid_d = valid_q;
    bits_d  = bits_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (accept) valid_d = 1'b0;

    if (active) begin
      presc_d = sample ? io_div : presc_q - 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (fall && io_en) begin
          presc_d = io_div >> 1;
          state_d = START;
        end
      end
      START: begin
        if (sample) begin
          if (!rx_q) begin
            bcnt_d  = 3'd0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {rx_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            scnt_d  = 1'b0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (sample) begin
          if (!rx_q) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end else if (io_nstop && !scnt_q) begin
            scnt_d = 1'b1;
          end else begin
            // Reload is allowed when the old byte drains this cycle.
            if (!valid_q || accept) begin
              valid_d = 1'b1;
              bits_d  = shift_q;
            end else begin
              ovr_d = 1'b1;
            end
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (active && !io_en) begin
      state_d = IDLE;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      valid_d = valid_q & ~accept;
      bits_d  = bits_q;
    end
  end

  assign io_out_valid = valid_q;
  assign io_out_bits  = bits_q;
  assign io_frame_err = ferr_q;
  assign io_overrun   = ovr_q;
  assign io_busy      = active;

endmodule

// File: tb/tb_n101_uartrx.sv
// Directed bench for n101_uartrx: table of frames plus
// hand sequences for glitch, overrun, back-to-back and aborts.
module tb_n101_uartrx;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_en = 1'b1;
  logic        io_in = 1'b1;
  logic [15:0] io_div = 16'd15;
  logic        io_nstop = 1'b0;
  logic        io_out_ready = 1'b1;
  logic        io_out_valid;
  logic [7:0]  io_out_bits;
  logic        io_frame_err;
  logic        io_overrun;
  logic        io_busy;

  n101_uartrx dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_en        (io_en),
    .io_in        (io_in),
    .io_div       (io_div),
    .io_nstop     (io_nstop),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_frame_err (io_frame_err),
    .io_overrun   (io_overrun),
    .io_busy      (io_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic       pv = 1'b0;
  int         nbytes = 0;
  int         nferr = 0;
  int         novr = 0;
  int         nbusy = 0;
  logic [7:0] got [64];
  int         vcyc [64];

  always @(negedge clock) begin
    if (io_out_valid && !pv && nbytes < 64) begin
      got[nbytes]  <= io_out_bits;
      vcyc[nbytes] <= cyc;
      nbytes       <= nbytes + 1;
    end
    pv <= io_out_valid;
    if (io_frame_err) nferr <= nferr + 1;
    if (io_overrun) novr <= novr + 1;
    if (io_busy) nbusy <= nbusy + 1;
  end

  int checks = 0;
  int failures = 0;
  int P = 16;
  int ecyc = 0;
  int b0, f0, o0, z0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(string nm, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic hold(logic v, int n);
    io_in = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic frame(logic [7:0] d, logic two,
                       logic s1, logic s2);
    ecyc = cyc;
    hold(1'b0, P);
    for (int i = 0; i < 8; i++) hold(d[i], P);
    hold(s1, P);
    if (two) hold(s2, P);
  endtask

  task automatic snap();
    b0 = nbytes;
    f0 = nferr;
    o0 = novr;
    z0 = nbusy;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       two;
    logic       s1;
    logic       s2;
    int         nb;
    int         nf;
  } vec_t;

  vec_t       tab [6];
  logic [7:0] bb [4];

  initial begin
    tab[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1, 0};
    tab[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 0, 1};
    tab[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 0, 1};
    tab[3] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1, 0};
    tab[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 0, 1};
    tab[5] = '{8'hFE, 1'b0, 1'b1, 1'b1, 1, 0};
    bb[0] = 8'h00;
    bb[1] = 8'hFF;
    bb[2] = 8'h55;
    bb[3] = 8'h80;

    repeat (3) @(negedge clock);
    chk("rst_valid", int'(io_out_valid), 0);
    chk("rst_bits", int'(io_out_bits), 0);
    chk("rst_ferr", int'(io_frame_err), 0);
    chk("rst_ovr", int'(io_overrun), 0);
    chk("rst_busy", int'(io_busy), 0);
    reset_n = 1'b1;
    hold(1'b1, 5);

    for (int r = 0; r < 6; r++) begin
      snap();
      io_nstop = tab[r].two;
      frame(tab[r].d, tab[r].two, tab[r].s1, tab[r].s2);
      hold(1'b1, 3 * P);
      chk($sformatf("row%0d_bytes", r), nbytes - b0, tab[r].nb);
      chk($sformatf("row%0d_ferr", r), nferr - f0, tab[r].nf);
      chk($sformatf("row%0d_ovr", r), novr - o0, 0);
      if (tab[r].nb == 1)
        chk($sformatf("row%0d_data", r),
            int'(got[b0]), int'(tab[r].d));
      if (r == 0)
        chk_rng("lat_a5", vcyc[b0] - ecyc, 148, 156);
    end
    io_nstop = 1'b0;

    snap();
    hold(1'b0, 4);
    hold(1'b1, 30);
    chk_rng("glitch_busy", nbusy - z0, 7, 10);
    chk("glitch_bytes", nbytes - b0, 0);
    chk("glitch_ferr", nferr - f0, 0);

    snap();
    hold(1'b0, 20 * P);
    hold(1'b1, 3 * P);
    chk("break_ferr", nferr - f0, 1);
    chk("break_bytes", nbytes - b0, 0);

    io_div = 16'd0;
    P = 1;
    snap();
    hold(1'b0, 1);
    hold(1'b1, 10);
    chk_rng("div0_busy", nbusy - z0, 1, 2);
    chk("div0_bytes", nbytes - b0, 0);
    chk("div0_ferr", nferr - f0, 0);

    io_div = 16'd7;
    P = 8;
    for (int ns = 0; ns < 2; ns++) begin
      io_nstop = ns[0];
      snap();
      for (int k = 0; k < 4; k++)
        frame(bb[k], ns[0], 1'b1, 1'b1);
      hold(1'b1, 3 * P);
      chk($sformatf("b2b%0d_cnt", ns), nbytes - b0, 4);
      for (int k = 0; k < 4; k++)
        chk($sformatf("b2b%0d_d%0d", ns, k),
            int'(got[b0 + k]), int'(bb[k]));
      chk($sformatf("b2b%0d_ferr", ns), nferr - f0, 0);
      chk($sformatf("b2b%0d_ovr", ns), novr - o0, 0);
    end
    io_nstop = 1'b0;

    io_div = 16'd15;
    P = 16;
    io_out_ready = 1'b0;
    snap();
    frame(8'h11, 1'b0, 1'b1, 1'b1);
    hold(1'b1, 3 * P);
    frame(8'h22, 1'b0, 1'b1, 1'b1);
    hold(1'b1, 3 * P);
    chk("ovr_valid", int'(io_out_valid), 1);
    chk("ovr_bits", int'(io_out_bits), 'h11);
    chk("ovr_pulse", novr - o0, 1);
    chk("ovr_bytes", nbytes - b0, 1);
    io_out_ready = 1'b1;
    @(negedge clock);
    io_out_ready = 1'b0;
    chk("drain_valid", int'(io_out_valid), 0);
    frame(8'h33, 1'b0, 1'b1, 1'b1);
    hold(1'b1, 3 * P);
    chk("ovr_next_bits", int'(io_out_bits), 'h33);
    chk("ovr_next_valid", int'(io_out_valid), 1);

    hold(1'b0, P);
    hold(1'b1, P);
    hold(1'b0, P);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(io_out_valid), 0);
    chk("mid_rst_bits", int'(io_out_bits), 0);
    chk("mid_rst_busy", int'(io_busy), 0);
    chk("mid_rst_ferr", int'(io_frame_err), 0);
    chk("mid_rst_ovr", int'(io_overrun), 0);
    io_in = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    io_out_ready = 1'b1;
    hold(1'b1, 3 * P);
    snap();
    frame(8'h5A, 1'b0, 1'b1, 1'b1);
    hold(1'b1, 3 * P);
    chk("post_rst_cnt", nbytes - b0, 1);
    chk("post_rst_data", int'(got[b0]), 'h5A);

    snap();
    hold(1'b0, P);
    hold(1'b1, P);
    hold(1'b0, 8);
    io_en = 1'b0;
    @(negedge clock);
    chk("en_abort_busy", int'(io_busy), 0);
    hold(1'b1, 3 * P);
    io_en = 1'b1;
    hold(1'b1, 12 * P);
    chk("en_abort_bytes", nbytes - b0, 0);
    chk("en_abort_ferr", nferr - f0, 0);
    chk("en_abort_ovr", novr - o0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/n101_uartrx.md
# n101_uartrx

UART serial receiver, the receive-side counterpart of `n101_uarttx` in the n101 peripheral set. It oversamples the asynchronous `io_in` line with the same `io_div` prescaler semantics as the transmitter and recovers 8N1/8N2 frames, LSB first. Each received byte goes into a one-entry holding buffer drained through a valid/ready handshake. Framing errors and overruns are reported as single-cycle pulses to the UART register block.

## Interface
- No parameters; data width fixed at 8 bits, divider width fixed at 16 bits.
- `clock`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `io_en`  in  1  receiver enable.
- `io_in`  in  1  serial line, asynchronous, idle high.
- `io_div`  in  16  bit period minus one, in clock cycles; same meaning as the transmitter's divider.
- `io_nstop`  in  1  0 = one stop bit, 1 = two stop bits.
- `io_out_valid`  out  1  holding buffer full.
- `io_out_ready`  in  1  consumer accepts the byte when `valid & ready`.
- `io_out_bits`  out  8  received byte.
- `io_frame_err`  out  1  one-cycle pulse: a stop bit was sampled low.
- `io_overrun`  out  1  one-cycle pulse: a byte completed while the buffer was full.
- `io_busy`  out  1  state is not IDLE.

## Operation
- Synchronizer: two flops on `io_in`, both reset to 1. `rx` is the second flop. `rx_d` is `rx` delayed one cycle and also resets to 1. A falling edge is `rx_d & ~rx`.
- State machine: IDLE, START, DATA, STOP.
- Prescaler: 16-bit down-counter. A sample point is any cycle in START, DATA or STOP with prescaler == 0. At a sample point the prescaler reloads `io_div`; otherwise it decrements. The prescaler holds its value in IDLE.
- IDLE: on a falling edge with `io_en`=1, load prescaler with `io_div >> 1` and go to START.
- START: at the sample point, if `rx`=0 clear the bit counter and go to DATA. If `rx`=1 it is a false start: go to IDLE with no flags raised.
- DATA: at each sample point, shifter <= {`rx`, shifter[7:1]} and the 3-bit bit counter increments. The sample at which the counter wraps from 7 to 0 is the 8th bit; go to STOP and clear the stop counter.
- STOP: at a sample point with `rx`=0, pulse `io_frame_err`, discard the byte and go to IDLE.
- STOP: at a sample point with `rx`=1 and `io_nstop`=1 and the first stop bit, set the stop counter and stay in STOP.
- STOP: otherwise the frame is complete. If `io_out_valid`=0, or `valid & ready` in that same cycle, load the buffer and set valid. Otherwise pulse `io_overrun`, drop the new byte and keep the old one. Go to IDLE in all these cases.
- Handshake: `valid & ready` clears valid on the next cycle unless a completing frame reloads the buffer in the same cycle; then valid stays 1 with the new byte. `io_out_bits` is stable while valid=1.
- `io_en` deasserted in any non-IDLE state: go to IDLE on the next clock, deliver no byte, raise no flags. The buffer is unaffected.
- A frame that ends in IDLE does not restart until a fresh 1→0 edge occurs. A line held low (break) therefore produces exactly one frame error.
- `io_div`/`io_nstop` changes mid-frame take effect at the next prescaler reload or stop decision; software must not change them while busy.

## Timing
- Reset values: `io_out_valid`=0, `io_out_bits`=0x00, `io_frame_err`=0, `io_overrun`=0, `io_busy`=0. State IDLE, prescaler 0, shifter 0.
- Bit period = `io_div`+1 cycles. The first sample point falls (`io_div`>>1)+1 cycles after the edge-detect cycle, so samples land at bit centres ±1 cycle.
- Input latency: 2 cycles of synchronizer plus 1 cycle of edge detect.
- `io_out_valid`, `io_frame_err` and `io_overrun` are registered and assert on the cycle after the deciding stop sample point.
- `io_div`=0 is legal: one cycle per bit, sampled every cycle; the edge detect must still work.
- Back-to-back frames with no idle gap: the start edge arrives about half a bit after the stop sample, while the receiver is already in IDLE. No frames are lost.

## Test plan
- Basic byte: `io_div`=15, `io_nstop`=0, ready=1, drive 0xA5 at 16 cycles/bit. Required: one valid pulse with bits=0xA5, 9.5 bit periods (±4 cycles) after the falling edge; no flags.
- Glitch: `io_div`=15, `io_in` low for 4 cycles, then high. Required: busy=1, then 0 after about 9 cycles; no valid, no flags.
- Framing error: `io_div`=15, byte 0x3C with stop bit driven 0. Required: `io_frame_err` pulses once and valid stays 0. Repeat with `io_nstop`=1, first stop high and second low: one frame error, no valid.
- Overrun: ready=0, send 0x11 then 0x22. Required: bits=0x11 stays valid and `io_overrun` pulses once. Raise ready for 1 cycle: valid drops. Send 0x33: bits=0x33.
- Loopback: connect `n101_uarttx` `io_out` to `io_in` with the same `io_div`=7 and both stop settings. Send 0x00, 0xFF, 0x55 and 0x80 back-to-back. Required: all four received in order with no errors.
- Reset/enable abort: assert `reset_n`=0 mid-DATA. Required: all outputs return to reset values immediately, and the next clean frame (0x5A) is received correctly. Deassert `io_en` mid-frame: busy=0 next cycle and no valid.
